// File: rtl/fb_pixel_generator_if.sv
// Pixel-stream interface between the video timing source / framebuffer RAM and fb_pixel_generator.
interface fb_pixel_generator_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              video_on;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic [ADDR_W-1:0] address_out;
    logic [7:0]        data_in;
    logic [2:0]        rgb;

    modport master (
        output video_on, pixel_x, pixel_y, data_in,
        input  address_out, rgb
    );

    modport slave (
        input  video_on, pixel_x, pixel_y, data_in,
        output address_out, rgb
    );
endinterface

// File: rtl/fb_pixel_generator.sv
// Framebuffer pixel generator: maps screen (x,y) to a packed framebuffer byte address and pixel colour.
// Optional palette compiled in with macro FB_PIXEL_GENERATOR_PALETTE_EN.
module fb_pixel_generator #(
    parameter int unsigned FB_W       = 320,
    parameter int unsigned FB_H       = 240,
    parameter int unsigned BPP        = 1,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned ADDR_W     = 14,
    parameter logic [2:0]  BORDER     = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
    input  logic                 pal_we,
    input  logic [3:0]           pal_addr,
    input  logic [2:0]           pal_data,
`endif
    fb_pixel_generator_if.slave  vid
);

    localparam int unsigned PPB     = 8 / BPP;
    localparam int unsigned SLOT_SH = $clog2(PPB);
    localparam int unsigned IDX_RAW = $clog2(FB_W * FB_H);
    localparam int unsigned IDX_W   = (IDX_RAW > 20) ? IDX_RAW : 20;
    localparam int unsigned SD_W    = 3 * RD_LAT;
`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
    localparam int unsigned PIX_W   = 4;
`else
    localparam int unsigned PIX_W   = 3;
`endif

    logic [9:0]        w_fx;
    logic [9:0]        w_fy;
    logic              w_in_area;
    logic [9:0]        r_fx;
    logic [9:0]        r_fy;
    logic              r_area0;
    logic              r_von0;
    logic [IDX_W-1:0]  w_index;
    logic [2:0]        w_slot;
    logic [ADDR_W-1:0] w_byte;
    logic [ADDR_W-1:0] r_addr;
    logic [RD_LAT-1:0] r_area_d;
    logic [RD_LAT-1:0] r_von_d;
    logic [SD_W-1:0]   r_slot_d;
    logic [2:0]        w_slot_t;
    logic [2:0]        w_off;
    logic [7:0]        w_sh;
    logic [PIX_W-1:0]  w_pix;
    logic [2:0]        w_col;
    logic [2:0]        r_rgb;

    // Stage 0: downscale and clip against the framebuffer
    assign w_fx      = vid.pixel_x >> SCALE_LOG2;
    assign w_fy      = vid.pixel_y >> SCALE_LOG2;
    assign w_in_area = vid.video_on && (32'(w_fx) < FB_W) && (32'(w_fy) < FB_H);

    // Pixel index is wide enough for the whole framebuffer; slot is the low bits within a byte
    assign w_index = IDX_W'(r_fy) * IDX_W'(FB_W) + IDX_W'(r_fx);
    assign w_slot  = w_index[2:0] & 3'(PPB - 1);
    assign w_byte  = ADDR_W'(w_index >> SLOT_SH);

    // Select the MSB-first pixel field from the returned byte
    assign w_slot_t = r_slot_d[SD_W-1 -: 3];
    assign w_off    = 3'(32'(w_slot_t) * BPP);
    assign w_sh     = vid.data_in << w_off;
    assign w_pix    = PIX_W'(w_sh >> (8 - BPP));

`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
    logic [2:0] r_pal [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) r_pal[4'(i)] <= 3'(i);
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    assign w_col = r_pal[w_pix];
`else
    always_comb begin
        w_col = w_pix[2:0];
        if (BPP == 1)      w_col = {3{w_pix[0]}};
        else if (BPP == 2) w_col = {w_pix[1], w_pix[0], w_pix[1]};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fx     <= '0;
            r_fy     <= '0;
            r_area0  <= 1'b0;
            r_von0   <= 1'b0;
            r_addr   <= '0;
            r_area_d <= '0;
            r_von_d  <= '0;
            r_slot_d <= '0;
            r_rgb    <= '0;
        end else begin
            r_fx    <= w_fx;
            r_fy    <= w_fy;
            r_area0 <= w_in_area;
            r_von0  <= vid.video_on;
            if (r_area0) r_addr <= w_byte;
            // Delay line keeps area/video_on/slot aligned with the RAM read data
            r_area_d <= RD_LAT'({r_area_d, r_area0});
            r_von_d  <= RD_LAT'({r_von_d, r_von0});
            r_slot_d <= SD_W'({r_slot_d, w_slot});
            if (r_area_d[RD_LAT-1])     r_rgb <= w_col;
            else if (r_von_d[RD_LAT-1]) r_rgb <= BORDER;
            else                        r_rgb <= 3'b000;
        end
    end

    assign vid.address_out = r_addr;
    assign vid.rgb         = r_rgb;

endmodule

// File: tb/tb_fb_pixel_generator.sv
// Directed self-checking bench for fb_pixel_generator across several parameter sets.
module tb_fb_pixel_generator;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fb_pixel_generator_if #(.ADDR_W(14)) a_if ();
    fb_pixel_generator_if #(.ADDR_W(14)) b_if ();
    fb_pixel_generator_if #(.ADDR_W(17)) c_if ();

`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
    // Identity palette after reset: a 1-bpp pixel of 1 reads entry 1
    localparam logic [2:0] A_ON = 3'b001;
    fb_pixel_generator_if #(.ADDR_W(14)) d_if ();
    logic       d_we;
    logic [3:0] d_wa;
    logic [2:0] d_wd;
`else
    localparam logic [2:0] A_ON = 3'b111;
`endif

    // A: defaults (BPP=1, SCALE_LOG2=1, RD_LAT=1)
    fb_pixel_generator u_a (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
        .pal_we   (1'b0),
        .pal_addr (4'd0),
        .pal_data (3'd0),
`endif
        .vid      (a_if)
    );

    // B: 4 bpp, downscale by 4
    fb_pixel_generator #(.BPP(4), .SCALE_LOG2(2)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
        .pal_we   (1'b0),
        .pal_addr (4'd0),
        .pal_data (3'd0),
`endif
        .vid      (b_if)
    );

    // C: 8 bpp, no scaling, three-cycle RAM, non-black border
    fb_pixel_generator #(.BPP(8), .SCALE_LOG2(0), .RD_LAT(3), .ADDR_W(17), .BORDER(3'b110)) u_c (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
        .pal_we   (1'b0),
        .pal_addr (4'd0),
        .pal_data (3'd0),
`endif
        .vid      (c_if)
    );

`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
    fb_pixel_generator #(.BPP(2)) u_d (
        .clk      (clk),
        .rst_n    (rst_n),
        .pal_we   (d_we),
        .pal_addr (d_wa),
        .pal_data (d_wd),
        .vid      (d_if)
    );
`endif

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_if.video_on = 1'b0; a_if.pixel_x = '0; a_if.pixel_y = '0; a_if.data_in = '0;
        b_if.video_on = 1'b0; b_if.pixel_x = '0; b_if.pixel_y = '0; b_if.data_in = '0;
        c_if.video_on = 1'b0; c_if.pixel_x = '0; c_if.pixel_y = '0; c_if.data_in = '0;
`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
        d_if.video_on = 1'b0; d_if.pixel_x = '0; d_if.pixel_y = '0; d_if.data_in = '0;
        d_we = 1'b0; d_wa = '0; d_wd = '0;
`endif
        tick(2);
        check("rst_a_addr", 32'(a_if.address_out), 32'd0);
        check("rst_a_rgb",  32'(a_if.rgb),         32'd0);
        check("rst_b_addr", 32'(b_if.address_out), 32'd0);
        check("rst_b_rgb",  32'(b_if.rgb),         32'd0);
        check("rst_c_addr", 32'(c_if.address_out), 32'd0);
        check("rst_c_rgb",  32'(c_if.rgb),         32'd0);
        rst_n = 1'b1;
        tick(1);

        // A: (6,4) -> fx=3, fy=2, index 643, byte 80, slot 3; then (4,2) -> index 322, byte 40, slot 2
        a_if.video_on = 1'b1; a_if.pixel_x = 10'd6; a_if.pixel_y = 10'd4;
        tick(1);
        a_if.pixel_x = 10'd4; a_if.pixel_y = 10'd2;
        check("a_addr_not_yet", 32'(a_if.address_out), 32'd0);
        tick(1);
        a_if.video_on = 1'b0;
        check("a_addr_80", 32'(a_if.address_out), 32'd80);
        a_if.data_in = 8'h10;
        tick(1);
        check("a_rgb_slot3", 32'(a_if.rgb),         32'(A_ON));
        check("a_addr_40",   32'(a_if.address_out), 32'd40);
        a_if.data_in = 8'h20;
        tick(1);
        check("a_rgb_slot2", 32'(a_if.rgb), 32'(A_ON));
        a_if.data_in = 8'hFF;
        tick(1);
        check("a_rgb_off",       32'(a_if.rgb),         32'd0);
        check("a_addr_held_off", 32'(a_if.address_out), 32'd40);

        // A: last framebuffer pixel (319,239) -> byte 9599, slot 7
        a_if.video_on = 1'b1; a_if.pixel_x = 10'd639; a_if.pixel_y = 10'd479;
        tick(1);
        a_if.video_on = 1'b0;
        tick(1);
        check("a_addr_last", 32'(a_if.address_out), 32'd9599);
        a_if.data_in = 8'h01;
        tick(1);
        check("a_rgb_last", 32'(a_if.rgb), 32'(A_ON));

        // B: (8,4) -> index 322, byte 161, slot 0; (2,0) -> byte 0, slot 0
        b_if.video_on = 1'b1; b_if.pixel_x = 10'd8; b_if.pixel_y = 10'd4;
        tick(1);
        b_if.pixel_x = 10'd2; b_if.pixel_y = 10'd0;
        tick(1);
        b_if.video_on = 1'b0;
        check("b_addr_161", 32'(b_if.address_out), 32'd161);
        b_if.data_in = 8'h3C;
        tick(1);
        check("b_addr_0", 32'(b_if.address_out), 32'd0);
        check("b_rgb_3c", 32'(b_if.rgb),         32'd3);
        b_if.data_in = 8'hA5;
        tick(1);
        check("b_rgb_a5", 32'(b_if.rgb), 32'b010);

        // C: pixel, border pixel, one-cycle blank, pixel; colours arrive 4 edges after sampling
        c_if.video_on = 1'b1; c_if.pixel_x = 10'd10; c_if.pixel_y = 10'd1;
        tick(1);
        c_if.pixel_x = 10'd400;
        tick(1);
        c_if.video_on = 1'b0; c_if.pixel_x = 10'd11;
        check("c_addr_330", 32'(c_if.address_out), 32'd330);
        tick(1);
        c_if.video_on = 1'b1; c_if.pixel_x = 10'd12;
        check("c_addr_border_hold", 32'(c_if.address_out), 32'd330);
        check("c_rgb_early",        32'(c_if.rgb),         32'd0);
        tick(1);
        c_if.video_on = 1'b0;
        check("c_addr_blank_hold", 32'(c_if.address_out), 32'd330);
        c_if.data_in = 8'h07;
        tick(1);
        check("c_addr_332", 32'(c_if.address_out), 32'd332);
        check("c_rgb_pix",  32'(c_if.rgb),         32'b111);
        tick(1);
        check("c_rgb_border", 32'(c_if.rgb), 32'b110);
        tick(1);
        check("c_rgb_blank", 32'(c_if.rgb), 32'd0);
        c_if.data_in = 8'h03;
        tick(1);
        check("c_rgb_after_blank", 32'(c_if.rgb), 32'b011);
        tick(1);
        check("c_rgb_off", 32'(c_if.rgb), 32'd0);

        // A: mid-line reset; (20,20) -> index 3210, byte 401
        a_if.video_on = 1'b1; a_if.pixel_x = 10'd20; a_if.pixel_y = 10'd20; a_if.data_in = 8'hFF;
        tick(3);
        check("a_pre_rst_rgb",  32'(a_if.rgb),         32'(A_ON));
        check("a_pre_rst_addr", 32'(a_if.address_out), 32'd401);
        #2;
        rst_n = 1'b0;
        #1;
        check("a_rst_rgb",  32'(a_if.rgb),         32'd0);
        check("a_rst_addr", 32'(a_if.address_out), 32'd0);
        check("c_rst_rgb",  32'(c_if.rgb),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("a_rel1_rgb",  32'(a_if.rgb),         32'd0);
        check("a_rel1_addr", 32'(a_if.address_out), 32'd0);
        tick(1);
        check("a_rel2_rgb",  32'(a_if.rgb),         32'd0);
        check("a_rel2_addr", 32'(a_if.address_out), 32'd401);
        tick(1);
        check("a_rel3_rgb", 32'(a_if.rgb), 32'(A_ON));
        a_if.video_on = 1'b0;

`ifdef FB_PIXEL_GENERATOR_PALETTE_EN
        // D: entry 1 rewritten, then a same-edge write/read of entry 1 returns the old entry
        d_wa = 4'd1; d_wd = 3'b100; d_we = 1'b1;
        tick(1);
        d_we = 1'b0;
        d_if.video_on = 1'b1; d_if.pixel_x = 10'd0; d_if.pixel_y = 10'd0; d_if.data_in = 8'h40;
        tick(3);
        check("d_rgb_pal1", 32'(d_if.rgb), 32'b100);
        d_wd = 3'b011; d_we = 1'b1;
        tick(1);
        d_we = 1'b0;
        check("d_rgb_same_edge", 32'(d_if.rgb), 32'b100);
        tick(1);
        check("d_rgb_new", 32'(d_if.rgb), 32'b011);
        d_if.video_on = 1'b0;
`endif

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
